comparator_sequencer: RTL and testbench
=======================================

# comparator_sequencer

Initiator for the bit-serial comparator's start/done handshake. It accepts operand pairs on a valid/ready input stream and drives one compare transaction at a time into an external comparator instance. It collects the AGB/AEB/ALB outcome, encoded as a result code, on a valid/ready output stream, and keeps saturating per-outcome statistics. It sits between the operand producer and the comparator and guards against a hung or misbehaving comparator with a timeout and a one-hot check.

## Interface
- DATA_WIDTH, 2: operand width; must match the attached comparator.
- TIMEOUT, 16: maximum WAIT cycles allowed for cmp_done (≥1).
- CNT_WIDTH, 8: width of each statistics counter.

- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  sequencer can accept a pair.
- in_a, in_b  input  DATA_WIDTH  operands.
- cmp_start  output  1  one-cycle start pulse to the comparator.
- cmp_a, cmp_b  output  DATA_WIDTH  operands to the comparator, held stable for the whole transaction.
- cmp_agb, cmp_aeb, cmp_alb  input  1  comparator flags; sampled only in the cmp_done cycle.
- cmp_done  input  1  comparator completion pulse.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts result.
- res_code  output  2  result encoding: 00 EQ, 01 GT, 10 LT, 11 error.
- cnt_gt, cnt_eq, cnt_lt  output  CNT_WIDTH  saturating outcome counters.
- err_timeout, err_onehot  output  1  sticky error flags.
- clr_stats  input  1  synchronous clear of the counters and sticky flags.

## Operation
- FSM states: IDLE, LAUNCH, WAIT, HOLD. Reset state is IDLE.
- IDLE
  - in_ready=1.
  - On in_valid: latch in_a/in_b into the operand registers and go to LAUNCH.
- LAUNCH
  - cmp_start=1 for exactly this cycle.
  - Clear the wait timer.
  - Go to WAIT.
- WAIT
  - On cmp_done, decode the flags and go to HOLD:
    - exactly one flag high: GT/EQ/LT code, and the matching counter increments;
    - otherwise: code 11, err_onehot←1, no counter change.
  - Without cmp_done the timer increments. If this is the TIMEOUT-th WAIT cycle: code 11, err_timeout←1, go to HOLD.
  - cmp_done has priority over timeout in the same cycle.
- HOLD
  - res_valid=1 and res_code stable.
  - On res_ready: go to IDLE.
- in_ready is high only in IDLE. There is no overlap between transactions.
- cmp_a/cmp_b always drive the operand registers. They change only on IDLE acceptance.
- cmp_done outside WAIT is ignored. This covers a late done after a timeout: no counter change, no flag change.
- Counters saturate at all-ones. No wrap is allowed.
- clr_stats clears all three counters and both sticky flags on the next edge. It wins over a same-cycle increment or error set. It does not affect the FSM or res_code.
- Timer width is $clog2(TIMEOUT+1).

## Timing
- Reset values:
  - state IDLE;
  - in_ready 1;
  - cmp_start 0;
  - cmp_a/cmp_b 0;
  - res_valid 0;
  - res_code 00;
  - counters 0;
  - error flags 0.
- Asserting rst mid-transaction returns to IDLE immediately (asynchronous). cmp_start drops in that same cycle.
- Cycle sequence:
  - Acceptance edge at cycle 0 (in_valid & in_ready).
  - cmp_start is high during cycle 1.
  - WAIT starts at cycle 2.
  - cmp_done sampled at the end of cycle k gives res_valid from cycle k+1, with counters updated at the same edge.
- Timeout with no done: res_valid rises in cycle 2+TIMEOUT.
- Result handshake: a transfer occurs on the edge where res_valid & res_ready. The next pair is acceptable one cycle later, in IDLE.
- Minimum per-transaction period: 4 cycles plus the comparator's done latency.

## Test plan
- DATA_WIDTH=2, behavioural comparator, a=3 b=1, res_ready=1 → one cmp_start pulse; res_code=01; cnt_gt=1; cmp_a=3 and cmp_b=1 held until done.
- Back-to-back pairs (2,2), then (0,3) → codes 00 then 10; cnt_eq=1, cnt_lt=1; in_ready low from acceptance until the result transfers.
- Comparator stub never asserts done, TIMEOUT=16 → res_valid in cycle 18 with code 11; err_timeout=1; counters unchanged. A done injected later is ignored.
- Stub returns agb=aeb=1 with done → code 11, err_onehot=1. clr_stats pulse → flags and counters return to 0.
- CNT_WIDTH=2, five GT results; res_ready held low for 5 cycles on the third → res_valid and code held stable while stalled; cnt_gt ends at 3 (saturated).
- rst asserted during WAIT → all outputs reach their reset values in the same cycle; the next accepted pair completes normally.

Source files
------------

// File: rtl/comparator_sequencer_if.sv
// Operand stream, comparator start/done bus, result stream and statistics.
// master: the sequencer; slave: producer/comparator/consumer side.
interface comparator_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 2,
  parameter int unsigned CNT_WIDTH  = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_a;
  logic [DATA_WIDTH-1:0] in_b;
  logic                  cmp_start;
  logic [DATA_WIDTH-1:0] cmp_a;
  logic [DATA_WIDTH-1:0] cmp_b;
  logic                  cmp_agb;
  logic                  cmp_aeb;
  logic                  cmp_alb;
  logic                  cmp_done;
  logic                  res_valid;
  logic                  res_ready;
  logic [1:0]            res_code;
  logic [CNT_WIDTH-1:0]  cnt_gt;
  logic [CNT_WIDTH-1:0]  cnt_eq;
  logic [CNT_WIDTH-1:0]  cnt_lt;
  logic                  err_timeout;
  logic                  err_onehot;
  logic                  clr_stats;

  modport master (
    input  in_valid, in_a, in_b, cmp_agb, cmp_aeb, cmp_alb, cmp_done,
           res_ready, clr_stats,
    output in_ready, cmp_start, cmp_a, cmp_b, res_valid, res_code,
           cnt_gt, cnt_eq, cnt_lt, err_timeout, err_onehot
  );

  modport slave (
    output in_valid, in_a, in_b, cmp_agb, cmp_aeb, cmp_alb, cmp_done,
           res_ready, clr_stats,
    input  in_ready, cmp_start, cmp_a, cmp_b, res_valid, res_code,
           cnt_gt, cnt_eq, cnt_lt, err_timeout, err_onehot
  );
endinterface

// File: rtl/comparator_sequencer.sv
// Start/done initiator for a bit-serial comparator with result stream,
// saturating outcome counters and sticky timeout/one-hot error flags.
// Ports: clk, rst (async, active-high), bus (comparator_sequencer_if.master).
module comparator_sequencer #(
  parameter int unsigned DATA_WIDTH = 2,
  parameter int unsigned TIMEOUT    = 16,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input logic                   clk,
  input logic                   rst,
  comparator_sequencer_if.master bus
);
  localparam int unsigned TIMER_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, HOLD} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [1:0]            code_q, code_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;
  logic [CNT_WIDTH-1:0]  gt_q, gt_d;
  logic [CNT_WIDTH-1:0]  eq_q, eq_d;
  logic [CNT_WIDTH-1:0]  lt_q, lt_d;
  logic                  err_to_q, err_to_d;
  logic                  err_oh_q, err_oh_d;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      code_q   <= '0;
      timer_q  <= '0;
      gt_q     <= '0;
      eq_q     <= '0;
      lt_q     <= '0;
      err_to_q <= 1'b0;
      err_oh_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      code_q   <= code_d;
      timer_q  <= timer_d;
      gt_q     <= gt_d;
      eq_q     <= eq_d;
      lt_q     <= lt_d;
      err_to_q <= err_to_d;
      err_oh_q <= err_oh_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    code_d   = code_q;
    timer_d  = timer_q;
    gt_d     = gt_q;
    eq_d     = eq_q;
    lt_d     = lt_q;
    err_to_d = err_to_q;
    err_oh_d = err_oh_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.cmp_done) begin
          state_d = HOLD;
          case ({bus.cmp_agb, bus.cmp_aeb, bus.cmp_alb})
            3'b100: begin
              code_d = 2'b01;
              gt_d   = sat_inc(gt_q);
            end
            3'b010: begin
              code_d = 2'b00;
              eq_d   = sat_inc(eq_q);
            end
            3'b001: begin
              code_d = 2'b10;
              lt_d   = sat_inc(lt_q);
            end
            default: begin
              code_d   = 2'b11;
              err_oh_d = 1'b1;
            end
          endcase
        end else if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
          // timer holds completed WAIT cycles, so this is the TIMEOUT-th one
          code_d   = 2'b11;
          err_to_d = 1'b1;
          state_d  = HOLD;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      HOLD: begin
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.clr_stats) begin
      gt_d     = '0;
      eq_d     = '0;
      lt_d     = '0;
      err_to_d = 1'b0;
      err_oh_d = 1'b0;
    end
  end

  // Decoded from state so an asynchronous reset drops them immediately.
  assign bus.in_ready    = (state_q == IDLE);
  assign bus.cmp_start   = (state_q == LAUNCH);
  assign bus.res_valid   = (state_q == HOLD);
  assign bus.cmp_a       = a_q;
  assign bus.cmp_b       = b_q;
  assign bus.res_code    = code_q;
  assign bus.cnt_gt      = gt_q;
  assign bus.cnt_eq      = eq_q;
  assign bus.cnt_lt      = lt_q;
  assign bus.err_timeout = err_to_q;
  assign bus.err_onehot  = err_oh_q;
endmodule

// File: tb/tb_comparator_sequencer.sv
module tb_comparator_sequencer;
  localparam int unsigned DW  = 2;
  localparam int unsigned TO  = 16;
  localparam int unsigned CW  = 2;
  localparam int CMAX = (1 << CW) - 1;
  localparam int M_OK = 0, M_NEVER = 1, M_BAD = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  comparator_sequencer_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  comparator_sequencer #(.DATA_WIDTH(DW), .TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state
  int exp_gt = 0, exp_eq = 0, exp_lt = 0, exp_to = 0, exp_oh = 0;

  // Comparator stub: responds 3+lat cycles after acceptance
  int   stub_mode = M_OK;
  int   stub_lat  = 0;
  int   stub_cnt;
  logic stub_busy, stub_done, stub_agb, stub_aeb, stub_alb;
  logic inject_done = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stub_busy <= 1'b0;
      stub_done <= 1'b0;
      stub_cnt  <= 0;
      stub_agb  <= 1'b0;
      stub_aeb  <= 1'b0;
      stub_alb  <= 1'b0;
    end else begin
      stub_done <= 1'b0;
      if (bus.cmp_start) begin
        if (stub_mode != M_NEVER) begin
          stub_busy <= 1'b1;
          stub_cnt  <= stub_lat;
        end
      end else if (stub_busy) begin
        if (stub_cnt == 0) begin
          stub_busy <= 1'b0;
          stub_done <= 1'b1;
          if (stub_mode == M_BAD) begin
            stub_agb <= 1'b1; stub_aeb <= 1'b1; stub_alb <= 1'b0;
          end else begin
            stub_agb <= (bus.cmp_a > bus.cmp_b);
            stub_aeb <= (bus.cmp_a == bus.cmp_b);
            stub_alb <= (bus.cmp_a < bus.cmp_b);
          end
        end else begin
          stub_cnt <= stub_cnt - 1;
        end
      end
    end
  end

  assign bus.cmp_done = stub_done | inject_done;
  assign bus.cmp_agb  = stub_agb;
  assign bus.cmp_aeb  = stub_aeb;
  assign bus.cmp_alb  = stub_alb;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_cnt_gt"}, 32'(bus.cnt_gt), exp_gt);
    check({tag, "_cnt_eq"}, 32'(bus.cnt_eq), exp_eq);
    check({tag, "_cnt_lt"}, 32'(bus.cnt_lt), exp_lt);
    check({tag, "_err_to"}, 32'(bus.err_timeout), exp_to);
    check({tag, "_err_oh"}, 32'(bus.err_onehot), exp_oh);
  endtask

  function automatic int ref_code(input int mode, input int a, input int b);
    if (mode != M_OK) return 3;
    if (a > b) return 1;
    if (a == b) return 0;
    return 2;
  endfunction

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic do_txn(input int a, input int b, input int mode, input int lat,
                        input int stall, input bit clr_at_done);
    int cyc, starts, rdy_bad, hold_bad, stall_bad, code, exp_lat;
    stub_mode = mode;
    stub_lat  = lat;
    check("in_ready_idle", 32'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_a     = DW'(a);
    bus.in_b     = DW'(b);
    tick();
    bus.in_valid = 1'b0;
    bus.in_a     = DW'($urandom);
    bus.in_b     = DW'($urandom);
    check("start_pulse", 32'(bus.cmp_start), 1);
    check("in_ready_busy", 32'(bus.in_ready), 0);
    check("cmp_a", 32'(bus.cmp_a), a);
    check("cmp_b", 32'(bus.cmp_b), b);
    cyc = 1; starts = 0; rdy_bad = 0; hold_bad = 0;
    while (bus.res_valid !== 1'b1 && cyc < int'(TO) + 20) begin
      if (clr_at_done && cyc == 3 + lat) bus.clr_stats = 1'b1;
      tick();
      bus.clr_stats = 1'b0;
      cyc++;
      if (bus.cmp_start !== 1'b0) starts++;
      if (bus.in_ready !== 1'b0) rdy_bad++;
      if (bus.cmp_a !== DW'(a) || bus.cmp_b !== DW'(b)) hold_bad++;
    end
    exp_lat = (mode == M_NEVER) ? 2 + int'(TO) : 4 + lat;
    code = ref_code(mode, a, b);
    if (clr_at_done) begin
      exp_gt = 0; exp_eq = 0; exp_lt = 0; exp_to = 0; exp_oh = 0;
    end else begin
      case (code)
        0: exp_eq = sat(exp_eq);
        1: exp_gt = sat(exp_gt);
        2: exp_lt = sat(exp_lt);
        default: if (mode == M_NEVER) exp_to = 1; else exp_oh = 1;
      endcase
    end
    check("res_latency", cyc, exp_lat);
    check("extra_start", starts, 0);
    check("in_ready_low", rdy_bad, 0);
    check("operand_hold", hold_bad, 0);
    check("res_valid", 32'(bus.res_valid), 1);
    check("res_code", 32'(bus.res_code), code);
    check_stats("result");
    stall_bad = 0;
    for (int i = 0; i < stall; i++) begin
      tick();
      if (bus.res_valid !== 1'b1 || bus.res_code !== 2'(code)) stall_bad++;
    end
    check("stall_stable", stall_bad, 0);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check("res_valid_drop", 32'(bus.res_valid), 0);
    check("back_to_idle", 32'(bus.in_ready), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    exp_gt = 0; exp_eq = 0; exp_lt = 0; exp_to = 0; exp_oh = 0;
    check({tag, "_in_ready"}, 32'(bus.in_ready), 1);
    check({tag, "_cmp_start"}, 32'(bus.cmp_start), 0);
    check({tag, "_cmp_a"}, 32'(bus.cmp_a), 0);
    check({tag, "_cmp_b"}, 32'(bus.cmp_b), 0);
    check({tag, "_res_valid"}, 32'(bus.res_valid), 0);
    check({tag, "_res_code"}, 32'(bus.res_code), 0);
    check_stats(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a, b, mode;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.res_ready = 1'b0;
    bus.clr_stats = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Basic GT, then EQ and LT back to back
    do_txn(3, 1, M_OK, 1, 0, 1'b0);
    do_txn(2, 2, M_OK, 0, 0, 1'b0);
    do_txn(0, 3, M_OK, 0, 0, 1'b0);

    // Timeout, then a late done must be ignored
    do_txn(1, 2, M_NEVER, 0, 0, 1'b0);
    inject_done = 1'b1;
    tick();
    inject_done = 1'b0;
    tick();
    check_stats("late_done");
    check("late_done_idle", 32'(bus.in_ready), 1);
    stub_mode = M_OK;

    // Non-one-hot flags, then clear
    do_txn(1, 1, M_BAD, 0, 0, 1'b0);
    bus.clr_stats = 1'b1;
    tick();
    bus.clr_stats = 1'b0;
    exp_gt = 0; exp_eq = 0; exp_lt = 0; exp_to = 0; exp_oh = 0;
    check_stats("clr");

    // Saturation with a stalled third result
    for (int i = 0; i < 5; i++) do_txn(3, 0, M_OK, i % 2, (i == 2) ? 5 : 0, 1'b0);
    check("gt_saturated", 32'(bus.cnt_gt), 3);

    // Clear beats a same-cycle increment
    do_txn(2, 1, M_OK, 2, 0, 1'b1);

    // Reset during LAUNCH
    stub_mode = M_OK; stub_lat = 5;
    bus.in_valid = 1'b1; bus.in_a = 2'd2; bus.in_b = 2'd1;
    tick();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_launch");
    #2 rst = 1'b0;
    tick();

    // Reset during WAIT, then a normal transaction
    do_txn(1, 3, M_OK, 0, 1, 1'b0);
    bus.in_valid = 1'b1; bus.in_a = 2'd3; bus.in_b = 2'd2;
    stub_lat = 5;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_wait");
    #2 rst = 1'b0;
    tick();
    tick();
    do_txn(3, 2, M_OK, 0, 0, 1'b0);

    // Randomized transactions
    for (int n = 0; n < 25; n++) begin
      a = int'($urandom_range(0, 3));
      b = int'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0: mode = M_BAD;
        1: mode = M_NEVER;
        default: mode = M_OK;
      endcase
      do_txn(a, b, mode, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
             (mode != M_NEVER) && ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 5) == 0) begin
        bus.clr_stats = 1'b1;
        tick();
        bus.clr_stats = 1'b0;
        exp_gt = 0; exp_eq = 0; exp_lt = 0; exp_to = 0; exp_oh = 0;
        check_stats("rand_clr");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
